pcie_cpl_splitter: RTL

Parametrised completer-side read-completion generator for the transaction layer. Accepts one decoded Memory Read request (address, DW length, tag, requester ID) and emits a sequence of completion descriptors that obey MAX_PAYLOAD and Read Completion Boundary rules. Each descriptor carries the `tlp_cpl_hdr_t` fields: length, byte count, lower address and last flag. It also carries a DW data offset for the payload fetch. Sits between RX request decode and the TX completion header builder.

---
 rtl/pcie_cpl_splitter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pcie_cpl_splitter.sv
// Read-completion splitter: turns one MRd request into MPS/RCB-legal completion descriptors.
// Optional macro PCIE_CPL_4K_CHK_EN answers 4 KB-crossing requests with a single UR descriptor.
module pcie_cpl_splitter #(
  parameter int MPS_DW = 128,
  parameter int RCB_DW = 16,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [9:0]        req_len_dw,
  input  logic [9:0]        req_tag,
  input  logic [15:0]       req_rid,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [9:0]        cpl_len_dw,
  output logic [11:0]       cpl_byte_cnt,
  output logic [6:0]        cpl_lower_addr,
  output logic [2:0]        cpl_status,
  output logic [9:0]        cpl_tag,
  output logic [15:0]       cpl_rid,
  output logic [10:0]       cpl_data_off_dw,
  output logic              cpl_last
);

  localparam int          RCB_LG = $clog2(RCB_DW);
  localparam logic [10:0] MPS_L  = 11'(MPS_DW);

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [10:0]       remain_r;
  logic [10:0]       off_r;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic [10:0]       nxt_remain_s;
  logic [10:0]       nxt_off_s;
  logic [10:0]       req_len_s;
  logic [10:0]       cur_chunk_s;
  logic [10:0]       room_s;
  logic [10:0]       nxt_chunk_s;
  logic              accept_s;
  logic              hshake_s;
  logic              load_s;
  logic              unused_s;

  assign req_len_s   = (req_len_dw == 10'd0) ? 11'd1024 : {1'b0, req_len_dw};
  assign cur_chunk_s = (cpl_len_dw == 10'd0) ? 11'd1024 : {1'b0, cpl_len_dw};
  assign accept_s    = req_valid && req_ready;
  assign hshake_s    = cpl_valid && cpl_ready;
  assign load_s      = (state_r == IDLE) ? accept_s : (hshake_s && !cpl_last);
  assign unused_s    = ^req_addr[1:0];

  // Position of the descriptor that will be presented next: fresh request or advance past current chunk
  always_comb begin
    nxt_addr_s   = cur_addr_r;
    nxt_remain_s = remain_r;
    nxt_off_s    = off_r;
    if (state_r == IDLE) begin
      nxt_addr_s   = {req_addr[ADDR_W-1:2], 2'b00};
      nxt_remain_s = req_len_s;
      nxt_off_s    = 11'd0;
    end else begin
      nxt_addr_s   = cur_addr_r + ADDR_W'({cur_chunk_s, 2'b00});
      nxt_remain_s = remain_r - cur_chunk_s;
      nxt_off_s    = off_r + cur_chunk_s;
    end
  end

  // Room up to the MPS limit measured from the enclosing RCB boundary keeps later chunks RCB-aligned
  assign room_s      = MPS_L - 11'(nxt_addr_s[2 +: RCB_LG]);
  assign nxt_chunk_s = (nxt_remain_s < room_s) ? nxt_remain_s : room_s;

`ifdef PCIE_CPL_4K_CHK_EN
  logic [12:0] end_off_s;
  logic        cross_s;
  assign end_off_s = {1'b0, req_addr[11:0]} + {req_len_s, 2'b00};
  assign cross_s   = (end_off_s > 13'd4096);
`else
  assign cpl_status = 3'b000;
`endif

  // Control FSM plus registered descriptor outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      req_ready       <= 1'b1;
      cpl_valid       <= 1'b0;
      cur_addr_r      <= '0;
      remain_r        <= 11'd0;
      off_r           <= 11'd0;
      cpl_len_dw      <= 10'd0;
      cpl_byte_cnt    <= 12'd0;
      cpl_lower_addr  <= 7'd0;
      cpl_tag         <= 10'd0;
      cpl_rid         <= 16'd0;
      cpl_data_off_dw <= 11'd0;
      cpl_last        <= 1'b0;
`ifdef PCIE_CPL_4K_CHK_EN
      cpl_status      <= 3'b000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r   <= SPLIT;
            req_ready <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_tag   <= req_tag;
            cpl_rid   <= req_rid;
          end
        end
        SPLIT: begin
          if (hshake_s && cpl_last) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            cpl_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          cpl_valid <= 1'b0;
        end
      endcase
      if (load_s) begin
        cur_addr_r      <= nxt_addr_s;
        remain_r        <= nxt_remain_s;
        off_r           <= nxt_off_s;
        cpl_len_dw      <= nxt_chunk_s[9:0];
        cpl_byte_cnt    <= {nxt_remain_s[9:0], 2'b00};
        cpl_lower_addr  <= nxt_addr_s[6:0];
        cpl_data_off_dw <= nxt_off_s;
        cpl_last        <= (nxt_chunk_s == nxt_remain_s);
`ifdef PCIE_CPL_4K_CHK_EN
        cpl_status      <= 3'b000;
`endif
      end
`ifdef PCIE_CPL_4K_CHK_EN
      // A 4 KB-crossing request collapses into one UR descriptor with no payload
      if ((state_r == IDLE) && accept_s && cross_s) begin
        cpl_status      <= 3'b001;
        cpl_len_dw      <= 10'd0;
        cpl_byte_cnt    <= 12'd4;
        cpl_lower_addr  <= req_addr[6:0];
        cpl_data_off_dw <= 11'd0;
        cpl_last        <= 1'b1;
      end
`endif
    end
  end

endmodule
